// File: rtl/uncache_store_buffer.sv
// Store buffer in front of the uncached AXI port: queues uncached stores, drains them
// one at a time, and holds uncached loads until every older store has completed.
module uncache_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [2:0]  st_size,
    input  logic [3:0]  st_wstrb,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_size,
    output logic        ld_rdy,
    output logic        ld_ret_valid,
    output logic [31:0] ld_ret_data,
    output logic        uncache_wr_req,
    output logic [31:0] uncache_wr_addr,
    output logic [2:0]  uncache_wr_size,
    output logic [3:0]  uncache_wr_wstrb,
    output logic [31:0] uncache_wr_data,
    input  logic        uncache_wr_rdy,
    input  logic        uncache_wr_bvalid,
    output logic        uncache_rd_req,
    output logic [31:0] uncache_rd_addr,
    output logic [2:0]  uncache_rd_size,
    input  logic        uncache_rd_rdy,
    input  logic        uncache_ret_valid,
    input  logic [31:0] uncache_ret_data,
    output logic        sb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = (PTR_W)'(1);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;

    wstate_t          state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             ld_pending_reg;
    logic             push, pop, ld_go;

    logic [31:0] addr_mem  [DEPTH];
    logic [2:0]  size_mem  [DEPTH];
    logic [3:0]  wstrb_mem [DEPTH];
    logic [31:0] data_mem  [DEPTH];

    assign st_ready = (count_reg != FULL_COUNT);
    assign push     = st_req && st_ready;
    assign pop      = (state_reg == W_RESP) && uncache_wr_bvalid;
    assign sb_empty = (count_reg == '0) && (state_reg == W_IDLE);

    // Head fields stay on the bus through W_RESP because wstrb is sampled in the data phase.
    assign uncache_wr_req   = (state_reg == W_ADDR);
    assign uncache_wr_addr  = addr_mem[rd_ptr_reg];
    assign uncache_wr_size  = size_mem[rd_ptr_reg];
    assign uncache_wr_wstrb = wstrb_mem[rd_ptr_reg];
    assign uncache_wr_data  = data_mem[rd_ptr_reg];

    assign ld_go           = ld_req && sb_empty && !ld_pending_reg;
    assign uncache_rd_req  = ld_go;
    assign uncache_rd_addr = ld_addr;
    assign uncache_rd_size = ld_size;
    assign ld_rdy          = ld_go && uncache_rd_rdy;
    assign ld_ret_valid    = uncache_ret_valid;
    assign ld_ret_data     = uncache_ret_data;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg]  <= st_addr;
            size_mem[wr_ptr_reg]  <= st_size;
            wstrb_mem[wr_ptr_reg] <= st_wstrb;
            data_mem[wr_ptr_reg]  <= st_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            W_IDLE: if (count_reg != '0) state_next = W_ADDR;
            W_ADDR: if (uncache_wr_rdy) state_next = W_RESP;
            // A response is only honoured here, never in the cycle the address is accepted.
            W_RESP: if (uncache_wr_bvalid) state_next = (count_next != '0) ? W_ADDR : W_IDLE;
            default: state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= W_IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            ld_pending_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (ld_rdy)
                ld_pending_reg <= 1'b1;
            else if (uncache_ret_valid)
                ld_pending_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uncache_store_buffer.sv
// Directed bench for uncache_store_buffer: a queue-based ordering model checked every cycle,
// plus literal expectations for latency, ordering and reset behaviour.
module tb_uncache_store_buffer;
    localparam int DEPTH = 4;

    logic        clk, resetn;
    logic        st_req;
    logic [31:0] st_addr;
    logic [2:0]  st_size;
    logic [3:0]  st_wstrb;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_size;
    logic        ld_rdy, ld_ret_valid;
    logic [31:0] ld_ret_data;
    logic        uncache_wr_req;
    logic [31:0] uncache_wr_addr;
    logic [2:0]  uncache_wr_size;
    logic [3:0]  uncache_wr_wstrb;
    logic [31:0] uncache_wr_data;
    logic        uncache_wr_rdy, uncache_wr_bvalid;
    logic        uncache_rd_req;
    logic [31:0] uncache_rd_addr;
    logic [2:0]  uncache_rd_size;
    logic        uncache_rd_rdy, uncache_ret_valid;
    logic [31:0] uncache_ret_data;
    logic        sb_empty;

    uncache_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_wstrb(st_wstrb),
        .st_data(st_data), .st_ready(st_ready),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_rdy(ld_rdy),
        .ld_ret_valid(ld_ret_valid), .ld_ret_data(ld_ret_data),
        .uncache_wr_req(uncache_wr_req), .uncache_wr_addr(uncache_wr_addr),
        .uncache_wr_size(uncache_wr_size), .uncache_wr_wstrb(uncache_wr_wstrb),
        .uncache_wr_data(uncache_wr_data), .uncache_wr_rdy(uncache_wr_rdy),
        .uncache_wr_bvalid(uncache_wr_bvalid),
        .uncache_rd_req(uncache_rd_req), .uncache_rd_addr(uncache_rd_addr),
        .uncache_rd_size(uncache_rd_size), .uncache_rd_rdy(uncache_rd_rdy),
        .uncache_ret_valid(uncache_ret_valid), .uncache_ret_data(uncache_ret_data),
        .sb_empty(sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required earlier $finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } st_t;

    // Model: stores queued but not yet acknowledged, in program order.
    st_t         q[$];
    logic [31:0] issued_q[$];
    int          compared = 0, mismatched = 0;
    int          cyc = 0, head_ready = 0;
    logic        accepted = 1'b0, ld_pend_m = 1'b0, wr_stall = 1'b0;
    logic [31:0] ld_addr_m = '0, r_addr = '0, last_ret_data = '0;
    int          b_cnt = 0, r_cnt = 0, b_delay = 3, r_delay = 2;
    int          last_bvalid_cyc = -1, last_ldrdy_cyc = -1, last_ret_cyc = -1, wr_req_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: wait bound expired at cycle %0d, required DUT event", name, cyc);
    endtask

    function automatic logic [31:0] rd_value(input logic [31:0] a);
        return {16'hCAFE, a[17:2]};
    endfunction

    task automatic model_step();
        logic exp_wr_req, exp_rd_req, exp_ld_rdy, push_m, pop_m;
        st_t  e;
        if (!resetn) begin
            q.delete();
            accepted  = 1'b0;
            ld_pend_m = 1'b0;
            b_cnt     = 0;
            r_cnt     = 0;
            chk("rst_st_ready", st_ready, 1);
            chk("rst_sb_empty", sb_empty, 1);
            chk("rst_wr_req", uncache_wr_req, 0);
            chk("rst_ld_rdy", ld_rdy, 0);
            chk("rst_ld_ret_valid", ld_ret_valid, 0);
            cyc++;
            return;
        end
        exp_wr_req = (q.size() != 0) && !accepted && (cyc >= head_ready);
        chk("st_ready", st_ready, q.size() < DEPTH);
        chk("sb_empty", sb_empty, q.size() == 0);
        chk("wr_req", uncache_wr_req, exp_wr_req);
        if (q.size() != 0 && cyc >= head_ready) begin
            chk("wr_addr", uncache_wr_addr, q[0].addr);
            chk("wr_size", uncache_wr_size, q[0].size);
            chk("wr_wstrb", uncache_wr_wstrb, q[0].wstrb);
            chk("wr_data", uncache_wr_data, q[0].data);
        end
        exp_rd_req = ld_req && (q.size() == 0) && !ld_pend_m;
        exp_ld_rdy = exp_rd_req && uncache_rd_rdy;
        chk("rd_req", uncache_rd_req, exp_rd_req);
        chk("ld_rdy", ld_rdy, exp_ld_rdy);
        if (exp_rd_req) begin
            chk("rd_addr", uncache_rd_addr, ld_addr);
            chk("rd_size", uncache_rd_size, ld_size);
        end
        chk("ld_ret_valid", ld_ret_valid, uncache_ret_valid);
        if (uncache_ret_valid) chk("ld_ret_data", ld_ret_data, rd_value(ld_addr_m));

        // Downstream responder bookkeeping and event timestamps.
        if (uncache_wr_req && uncache_wr_rdy) begin
            issued_q.push_back(uncache_wr_data);
            b_cnt = b_delay;
            $display("[%0d] WR issue addr=%h data=%h", cyc, uncache_wr_addr, uncache_wr_data);
        end
        if (uncache_wr_req) wr_req_seen++;
        if (uncache_wr_bvalid) last_bvalid_cyc = cyc;
        if (ld_rdy) begin
            r_cnt = r_delay;
            r_addr = uncache_rd_addr;
            last_ldrdy_cyc = cyc;
            $display("[%0d] LD issue addr=%h", cyc, uncache_rd_addr);
        end
        if (uncache_ret_valid) begin
            last_ret_cyc = cyc;
            last_ret_data = ld_ret_data;
            $display("[%0d] LD return data=%h", cyc, ld_ret_data);
        end

        push_m = st_req && (q.size() < DEPTH);
        pop_m  = accepted && uncache_wr_bvalid;
        if (pop_m) begin
            $display("[%0d] ST done addr=%h data=%h", cyc, q[0].addr, q[0].data);
            void'(q.pop_front());
            accepted = 1'b0;
        end else if (exp_wr_req && uncache_wr_rdy) begin
            accepted = 1'b1;
        end
        if (push_m) begin
            e.addr = st_addr; e.size = st_size; e.wstrb = st_wstrb; e.data = st_data;
            q.push_back(e);
            $display("[%0d] ST push addr=%h data=%h", cyc, st_addr, st_data);
        end
        // A new head is presentable one cycle after a pop, or two after a push into an empty buffer.
        if (pop_m && q.size() != 0)
            head_ready = cyc + 1;
        else if (push_m && !pop_m && q.size() == 1)
            head_ready = cyc + 2;
        if (exp_ld_rdy) begin
            ld_pend_m = 1'b1;
            ld_addr_m = ld_addr;
        end else if (uncache_ret_valid) begin
            ld_pend_m = 1'b0;
        end
        cyc++;
    endtask

    task automatic drive_responder();
        uncache_wr_bvalid = 1'b0;
        uncache_ret_valid = 1'b0;
        uncache_ret_data  = '0;
        if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) uncache_wr_bvalid = 1'b1;
        end
        if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) begin
                uncache_ret_valid = 1'b1;
                uncache_ret_data  = rd_value(r_addr);
            end
        end
        uncache_wr_rdy = !wr_stall;
        uncache_rd_rdy = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        drive_responder();
    endtask

    task automatic wait_st_ready(input string name);
        int n = 0;
        #1;
        while (!st_ready && n < 200) begin
            tick();
            #1;
            n++;
        end
        if (n == 200) timeout_fail(name);
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        st_req = 1'b1; st_addr = a; st_data = d; st_wstrb = s; st_size = 3'd2;
        wait_st_ready("push_wait");
        tick();
        st_req = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a);
        int n = 0;
        ld_req = 1'b1; ld_addr = a; ld_size = 3'd2;
        #1;
        while (!ld_rdy && n < 200) begin
            tick();
            #1;
            n++;
        end
        if (n == 200) timeout_fail("load_wait");
        tick();
        ld_req = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        #1;
        while ((!sb_empty || b_cnt != 0 || r_cnt != 0) && n < 200) begin
            tick();
            #1;
            n++;
        end
        if (n == 200) timeout_fail("drain_wait");
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        st_req = 1'b0; st_addr = '0; st_size = '0; st_wstrb = '0; st_data = '0;
        ld_req = 1'b0; ld_addr = '0; ld_size = '0;
        uncache_wr_rdy = 1'b0; uncache_wr_bvalid = 1'b0;
        uncache_rd_rdy = 1'b0; uncache_ret_valid = 1'b0; uncache_ret_data = '0;
        tick();
        tick();
        #1 chk("reset_st_ready", st_ready, 1);
        chk("reset_sb_empty", sb_empty, 1);
        chk("reset_wr_req", uncache_wr_req, 0);
        resetn = 1'b1;
        tick();

        // Single store: issued two cycles after push, popped by a response three cycles later.
        push_store(32'hBFAF_F000, 32'h1234_5678, 4'hF);
        #1 chk("t1_c1_wr_req", uncache_wr_req, 0);
        tick();
        #1 chk("t1_c2_wr_req", uncache_wr_req, 1);
        chk("t1_wr_addr", uncache_wr_addr, 32'hBFAF_F000);
        chk("t1_wr_data", uncache_wr_data, 32'h1234_5678);
        chk("t1_wr_wstrb", uncache_wr_wstrb, 4'hF);
        tick();
        #1 chk("t1_c3_wr_req", uncache_wr_req, 0);
        tick();
        tick();
        #1 chk("t1_c5_bvalid", uncache_wr_bvalid, 1);
        chk("t1_c5_sb_empty", sb_empty, 0);
        tick();
        #1 chk("t1_c6_sb_empty", sb_empty, 1);
        wait_empty();

        // Five stores against a stalled downstream: the fifth waits for the first pop.
        issued_q.delete();
        wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_store(32'hBFAF_0000 + 32'(4 * i), 32'(i), 4'hF);
        st_req = 1'b1; st_addr = 32'hBFAF_0010; st_data = 32'd4; st_wstrb = 4'h3; st_size = 3'd1;
        #1 chk("t2_full_st_ready", st_ready, 0);
        wr_stall = 1'b0;
        wait_st_ready("t2_fifth_wait");
        chk("t2_fifth_after_bvalid", (last_bvalid_cyc >= 0) ? 1 : 0, 1);
        tick();
        st_req = 1'b0;
        wait_empty();
        chk("t2_issued_n", issued_q.size(), 5);
        for (int i = 0; i < issued_q.size(); i++) chk("t2_order", issued_q[i], 32'(i));

        // Load behind a store waits until the cycle after the store's response.
        push_store(32'hBFD0_0000, 32'hA5A5_0000, 4'hF);
        do_load(32'hBFD0_0004);
        chk("t3_ld_after_bvalid", last_ldrdy_cyc, last_bvalid_cyc + 1);
        wait_empty();
        chk("t3_ld_ret_data", last_ret_data, 32'hCAFE_0001);

        // Push in the same cycle as a pop with two entries queued.
        issued_q.delete();
        push_store(32'hBFC0_0000, 32'hAAAA_0001, 4'hF);
        push_store(32'hBFC0_0004, 32'hAAAA_0002, 4'hF);
        begin
            int n = 0;
            #1;
            while (!uncache_wr_bvalid && n < 50) begin
                tick();
                #1;
                n++;
            end
            if (n == 50) timeout_fail("t4_bvalid_wait");
        end
        st_req = 1'b1; st_addr = 32'hBFC0_0008; st_data = 32'hAAAA_0003; st_wstrb = 4'hC;
        chk("t4_st_ready_count2", st_ready, 1);
        tick();
        st_req = 1'b0;
        #1 chk("t4_sb_empty", sb_empty, 0);
        wait_empty();
        chk("t4_issued_n", issued_q.size(), 3);
        for (int i = 0; i < issued_q.size(); i++) chk("t4_order", issued_q[i], 32'hAAAA_0001 + 32'(i));

        // Asynchronous reset in W_RESP with three entries queued discards everything.
        b_delay = 10;
        for (int i = 0; i < 3; i++) push_store(32'hBFE0_0000 + 32'(4 * i), 32'hDEAD_0000 + 32'(i), 4'hF);
        tick();
        resetn = 1'b0;
        #1 chk("t5_async_st_ready", st_ready, 1);
        chk("t5_async_sb_empty", sb_empty, 1);
        chk("t5_async_wr_req", uncache_wr_req, 0);
        tick();
        tick();
        resetn = 1'b1;
        wr_req_seen = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("t5_no_stale_writes", wr_req_seen, 0);
        b_delay = 3;

        // Second load waits for both the first load's data and the younger store's response.
        r_delay = 8;
        do_load(32'hBFD0_0010);
        push_store(32'hBFD0_0020, 32'h0000_0066, 4'hF);
        do_load(32'hBFD0_0024);
        chk("t6_ld2_gate", last_ldrdy_cyc,
            ((last_ret_cyc > last_bvalid_cyc) ? last_ret_cyc : last_bvalid_cyc) + 1);
        wait_empty();
        chk("t6_ld2_data", last_ret_data, 32'hCAFE_0009);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uncache_store_buffer.md
Name: uncache_store_buffer

Overview:
- Sits directly upstream of the uncache port of the CPU AXI interface.
- Queues uncached stores from the memory stage in a FIFO, so the pipeline does not wait on each store's write response.
- Drains the FIFO in order, one store at a time: present the store, wait for acceptance, wait for the write response, then pop.
- Holds uncached loads until every older store has completed (strong ordering for MMIO), then passes each load through to the read port.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
st_req  in  1  memory stage presents an uncached store
st_addr  in  32  store address
st_size  in  3  AXI size
st_wstrb  in  4  byte strobes
st_data  in  32  store data
st_ready  out  1  store accepted this cycle (st_req && st_ready = push)
ld_req  in  1  uncached load request
ld_addr  in  32  load address
ld_size  in  3  AXI size
ld_rdy  out  1  load address accepted
ld_ret_valid  out  1  load data valid
ld_ret_data  out  32  load data
uncache_wr_req  out  1  to interface
uncache_wr_addr  out  32  to interface
uncache_wr_size  out  3  to interface
uncache_wr_wstrb  out  4  to interface
uncache_wr_data  out  32  to interface
uncache_wr_rdy  in  1  write address accepted (data is captured downstream in the same cycle)
uncache_wr_bvalid  in  1  write response, one-cycle pulse
uncache_rd_req  out  1  to interface
uncache_rd_addr  out  32  to interface
uncache_rd_size  out  3  to interface
uncache_rd_rdy  in  1  read address accepted
uncache_ret_valid  in  1  read data valid
uncache_ret_data  in  32  read data
sb_empty  out  1  FIFO empty and write FSM in W_IDLE (fence/sync may retire)

Behaviour:
Reset and FIFO
- Reset (resetn low, async): wr_ptr, rd_ptr, count = 0; write FSM = W_IDLE; ld_pending = 0.
- Outputs in reset: st_ready = 1, sb_empty = 1; all *_req, ld_rdy, ld_ret_valid = 0.
- FIFO storage is not reset.
- count is PTR_W+1 bits. st_ready = (count != DEPTH).
- Push writes {addr, size, wstrb, data} at wr_ptr. Pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave count unchanged. This is legal when full: st_ready stays 0 that cycle, so no push actually occurs.
- No store-to-store merging and no same-cycle bypass. A pushed entry is first visible at the head in the next cycle.

Write FSM (W_IDLE, W_ADDR, W_RESP)
- W_IDLE: if count != 0, go to W_ADDR next cycle.
- W_ADDR:
  - uncache_wr_req = 1; head fields drive uncache_wr_addr/size/wstrb/data combinationally.
  - On uncache_wr_rdy, go to W_RESP.
- W_RESP:
  - uncache_wr_req = 0; head fields stay driven and stable (the interface samples wstrb during its data phase).
  - On uncache_wr_bvalid: pop head (rd_ptr++, count--). Go to W_ADDR if count after pop is nonzero, else W_IDLE.
- Minimum store occupancy: push at cycle 0 gives W_ADDR at cycle 2. uncache_wr_bvalid arriving in the same cycle as uncache_wr_rdy is ignored; bvalid is only honoured in W_RESP.

Load path
- Load gate: ld_go = ld_req && sb_empty && !ld_pending.
- uncache_rd_req = ld_go. ld_addr/ld_size pass combinationally to uncache_rd_addr/size.
- ld_rdy = ld_go && uncache_rd_rdy.
- ld_rdy sets ld_pending. uncache_ret_valid clears it, and ld_ret_valid/ld_ret_data forward uncache_ret_valid/uncache_ret_data combinationally.
- Only one load is outstanding at a time.
- Stores may still be pushed while a load is held or pending; they are younger in program order.
- A load request held behind stores simply stalls; the requester keeps ld_req and its fields stable.

Reset mid-transaction
- Async reset mid-transaction discards queued entries and any outstanding handshake. The interconnect is reset in the same reset domain.

Test Plan:
1. Single store addr=0xBFAF_F000, data=0x1234_5678, wstrb=0xF; wr_rdy in W_ADDR cycle, bvalid 3 cycles later -> uncache_wr_req high exactly 1 cycle at cycle 2 with those fields; pop on bvalid; sb_empty=1 next cycle.
2. Push 5 stores back-to-back, DEPTH=4, downstream stalled (wr_rdy=0) -> st_ready low on 5th attempt; after first bvalid, 5th store accepted; all 5 issued in push order, data 0..4.
3. Store to 0xBFD0_0000 then load from 0xBFD0_0004 one cycle later -> uncache_rd_req stays 0 until the cycle after the store's bvalid; load then issued; ld_ret_data = 0xCAFE_0001 when the model returns it.
4. Push and pop in the same cycle with count=2 -> count remains 2; the new entry is issued after the existing one.
5. Assert resetn low while in W_RESP with 3 entries queued -> immediately st_ready=1, sb_empty=1, uncache_wr_req=0; after release, no stale writes are issued.
6. Load pending, a new store pushed, then a second ld_req -> second load blocked (ld_rdy=0) until the first ld_ret_valid and the store's bvalid.
